// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings,
// the NOP instruction word and the default reset PC.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FS_FETCH  = 2'd0,
    FS_DECODE = 2'd1,
    FS_EXEC   = 2'd2,
    FS_HOLD   = 2'd3
  } fs_state_t;

  localparam logic [15:0] NOP_INSTR        = 16'h0000;
  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master)
// and instruction memory (slave). The fetch address is the sequencer's pc.
interface fetch_sequencer_if;

  logic        imemReq;
  logic        imemAck;
  logic [15:0] imemData;

  modport master (output imemReq, input imemAck, input imemData);
  modport slave  (input imemReq, output imemAck, output imemData);

endinterface

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next-PC mux: absolute jump beats relative branch, which
// beats sequential increment. All arithmetic wraps modulo 2^PC_WIDTH.
module fetch_sequencer_pc_next_calc #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned OFFSET_WIDTH = 6
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic                    jmpEnable,
  input  logic                    branchEnable,
  input  logic [PC_WIDTH-1:0]     jmpDir,
  input  logic [OFFSET_WIDTH-1:0] branchDir,
  output logic [PC_WIDTH-1:0]     pcNext
);

  logic [PC_WIDTH-1:0] offset;

  assign offset = {{(PC_WIDTH-OFFSET_WIDTH){branchDir[OFFSET_WIDTH-1]}}, branchDir};

  // Priority select of the next program counter
  always_comb begin
    pcNext = pc + PC_WIDTH'(1);
    if (jmpEnable) begin
      pcNext = jmpDir;
    end else if (branchEnable) begin
      pcNext = pc + offset;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC per instruction.
// Optional single-step mode is enabled by defining FETCH_SEQ_STEP_EN, which
// adds the stepReq input and parks the FSM in HOLD after every EXEC.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 10,
  parameter int unsigned         OFFSET_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
`ifdef FETCH_SEQ_STEP_EN
  input  logic                    stepReq,
`endif
  fetch_sequencer_if.master       imem,
  input  logic                    jmpEnable,
  input  logic                    branchEnable,
  input  logic [PC_WIDTH-1:0]     jmpDir,
  input  logic [OFFSET_WIDTH-1:0] branchDir,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [15:0]             ir,
  output logic                    irValid,
  output logic                    execStrobe,
  output logic [1:0]              state
);

  fs_state_t           st;
  logic                fetching;
  logic [PC_WIDTH-1:0] pcNext;

  fetch_sequencer_pc_next_calc #(
    .PC_WIDTH     (PC_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_pc_next (
    .pc           (pc),
    .jmpEnable    (jmpEnable),
    .branchEnable (branchEnable),
    .jmpDir       (jmpDir),
    .branchDir    (branchDir),
    .pcNext       (pcNext)
  );

  // Without the step feature HOLD is unreachable; a stray HOLD behaves as FETCH
`ifdef FETCH_SEQ_STEP_EN
  assign fetching = (st == FS_FETCH);
`else
  assign fetching = (st == FS_FETCH) || (st == FS_HOLD);
`endif

  // Request is combinational from state and run; held low while in reset
  assign imem.imemReq = fetching && run && !reset;
  assign state        = st;

  // Sequencer FSM with pc/ir and registered decode/exec strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= FS_FETCH;
      pc         <= RESET_PC;
      ir         <= NOP_INSTR;
      irValid    <= 1'b0;
      execStrobe <= 1'b0;
    end else begin
      irValid    <= 1'b0;
      execStrobe <= 1'b0;
      case (st)
        FS_DECODE: begin
          st         <= FS_EXEC;
          execStrobe <= 1'b1;
        end
        FS_EXEC: begin
          pc <= pcNext;
`ifdef FETCH_SEQ_STEP_EN
          st <= FS_HOLD;
`else
          st <= FS_FETCH;
`endif
        end
`ifdef FETCH_SEQ_STEP_EN
        FS_HOLD: begin
          if (stepReq) begin
            st <= FS_FETCH;
          end
        end
`endif
        default: begin
          if (run && imem.imemAck) begin
            ir      <= imem.imemData;
            st      <= FS_DECODE;
            irValid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized instruction stream checked against a cycle-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        jmpEnable;
  logic        branchEnable;
  logic [9:0]  jmpDir;
  logic [5:0]  branchDir;
  logic [9:0]  pc;
  logic [15:0] ir;
  logic        irValid;
  logic        execStrobe;
  logic [1:0]  state;
`ifdef FETCH_SEQ_STEP_EN
  logic        stepReq;
`endif

  int          checks = 0;
  int          errors = 0;
  int          m_pc;
  logic [15:0] m_ir;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .PC_WIDTH     (10),
    .OFFSET_WIDTH (6),
    .RESET_PC     (10'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
`ifdef FETCH_SEQ_STEP_EN
    .stepReq      (stepReq),
`endif
    .imem         (bus.master),
    .jmpEnable    (jmpEnable),
    .branchEnable (branchEnable),
    .jmpDir       (jmpDir),
    .branchDir    (branchDir),
    .pc           (pc),
    .ir           (ir),
    .irValid      (irValid),
    .execStrobe   (execStrobe),
    .state        (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one complete instruction and check every cycle against the model.
  task automatic run_instr(input logic [15:0] data, input int delay, input logic j,
                           input logic b, input logic [9:0] jd, input logic [5:0] bd,
                           input int hold_wait);
    int off;
    for (int k = 0; k <= delay; k++) begin
      run           = 1'b1;
      bus.imemAck   = (k == delay);
      bus.imemData  = (k == delay) ? data : 16'($urandom);
      jmpEnable     = 1'($urandom);
      branchEnable  = 1'($urandom);
      jmpDir        = 10'($urandom);
      branchDir     = 6'($urandom);
      #1;
      checks++;
      if (state !== 2'd0 || bus.imemReq !== 1'b1 || irValid !== 1'b0 || execStrobe !== 1'b0) begin
        errors++;
        $display("FAIL fetch_ctl c%0d: state=%0d req=%b irValid=%b exec=%b, want 0 1 0 0",
                 k, state, bus.imemReq, irValid, execStrobe);
      end
      checks++;
      if (pc !== 10'(m_pc) || ir !== m_ir) begin
        errors++;
        $display("FAIL fetch_regs c%0d: pc=%0d ir=%h, want pc=%0d ir=%h", k, pc, ir, m_pc, m_ir);
      end
      tick();
    end
    m_ir = data;

    run          = 1'($urandom);
    bus.imemAck  = 1'($urandom);
    bus.imemData = 16'($urandom);
    #1;
    checks++;
    if (state !== 2'd1 || irValid !== 1'b1 || execStrobe !== 1'b0 || bus.imemReq !== 1'b0) begin
      errors++;
      $display("FAIL decode_ctl: state=%0d irValid=%b exec=%b req=%b, want 1 1 0 0",
               state, irValid, execStrobe, bus.imemReq);
    end
    checks++;
    if (pc !== 10'(m_pc) || ir !== m_ir) begin
      errors++;
      $display("FAIL decode_regs: pc=%0d ir=%h, want pc=%0d ir=%h", pc, ir, m_pc, m_ir);
    end
    tick();

    run          = 1'($urandom);
    jmpEnable    = j;
    branchEnable = b;
    jmpDir       = jd;
    branchDir    = bd;
    #1;
    checks++;
    if (state !== 2'd2 || execStrobe !== 1'b1 || irValid !== 1'b0 || bus.imemReq !== 1'b0) begin
      errors++;
      $display("FAIL exec_ctl: state=%0d exec=%b irValid=%b req=%b, want 2 1 0 0",
               state, execStrobe, irValid, bus.imemReq);
    end
    checks++;
    if (pc !== 10'(m_pc) || ir !== m_ir) begin
      errors++;
      $display("FAIL exec_regs: pc=%0d ir=%h, want pc=%0d ir=%h", pc, ir, m_pc, m_ir);
    end
    tick();

    if (j) begin
      m_pc = int'(jd);
    end else if (b) begin
      off = int'(bd);
      if (off >= 32) off = off - 64;
      m_pc = (m_pc + off + 1024) % 1024;
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
    jmpEnable    = 1'($urandom);
    branchEnable = 1'($urandom);

`ifdef FETCH_SEQ_STEP_EN
    stepReq = 1'b0;
    for (int i = 0; i < hold_wait; i++) begin
      run          = 1'b1;
      bus.imemAck  = 1'($urandom);
      bus.imemData = 16'($urandom);
      #1;
      checks++;
      if (state !== 2'd3 || bus.imemReq !== 1'b0 || irValid !== 1'b0 || execStrobe !== 1'b0 ||
          pc !== 10'(m_pc) || ir !== m_ir) begin
        errors++;
        $display("FAIL hold c%0d: state=%0d req=%b irValid=%b exec=%b pc=%0d ir=%h, want 3 0 0 0 %0d %h",
                 i, state, bus.imemReq, irValid, execStrobe, pc, ir, m_pc, m_ir);
      end
      tick();
    end
    stepReq = 1'b1;
    #1;
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL hold_before_step: state=%0d, want 3", state);
    end
    tick();
    stepReq = 1'b0;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL step_release: state=%0d, want 0", state);
    end
`else
    for (int i = 0; i < hold_wait; i++) begin
      run          = 1'b0;
      bus.imemAck  = 1'($urandom);
      bus.imemData = 16'($urandom);
      #1;
      checks++;
      if (state !== 2'd0 || bus.imemReq !== 1'b0 || irValid !== 1'b0 || execStrobe !== 1'b0 ||
          pc !== 10'(m_pc) || ir !== m_ir) begin
        errors++;
        $display("FAIL park c%0d: state=%0d req=%b irValid=%b exec=%b pc=%0d ir=%h, want 0 0 0 0 %0d %h",
                 i, state, bus.imemReq, irValid, execStrobe, pc, ir, m_pc, m_ir);
      end
      tick();
    end
`endif
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    run          = 1'b1;
    bus.imemAck  = 1'b1;
    bus.imemData = 16'hBEEF;
    tick();
    tick();
    checks++;
    if (state !== 2'd0 || pc !== 10'd0 || ir !== 16'h0000 || irValid !== 1'b0 ||
        execStrobe !== 1'b0 || bus.imemReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: state=%0d pc=%0d ir=%h irValid=%b exec=%b req=%b, want 0 0 0000 0 0 0",
               state, pc, ir, irValid, execStrobe, bus.imemReq);
    end
    reset = 1'b0;
    run   = 1'b0;
    #1;
    checks++;
    if (bus.imemReq !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: req=%b, want 0", bus.imemReq);
    end
    tick();
    checks++;
    if (state !== 2'd0 || ir !== 16'h0000) begin
      errors++;
      $display("FAIL ack_without_run: state=%0d ir=%h, want 0 0000", state, ir);
    end
    m_pc = 0;
    m_ir = 16'h0000;
  endtask

  task automatic test_basic();
    run_instr(16'h1234, 0, 1'b0, 1'b0, 10'd0, 6'd0, 0);
    run_instr(16'h1234, 0, 1'b0, 1'b0, 10'd0, 6'd0, 0);
    checks++;
    if (pc !== 10'd2) begin
      errors++;
      $display("FAIL basic_pc: pc=%0d, want 2", pc);
    end
  endtask

  task automatic test_ack_delay();
    run_instr(16'h5A5A, 4, 1'b0, 1'b0, 10'd0, 6'd0, 0);
    checks++;
    if (pc !== 10'd3 || ir !== 16'h5A5A) begin
      errors++;
      $display("FAIL ack_delay: pc=%0d ir=%h, want 3 5a5a", pc, ir);
    end
  endtask

  task automatic test_jump_priority();
    run_instr(16'h0101, 0, 1'b1, 1'b0, 10'd5, 6'd0, 0);
    run_instr(16'h0202, 1, 1'b1, 1'b1, 10'h3F0, 6'b000011, 0);
    checks++;
    if (pc !== 10'h3F0) begin
      errors++;
      $display("FAIL jump_priority: pc=%h, want 3f0", pc);
    end
  endtask

  task automatic test_branch_wrap();
    run_instr(16'h0303, 0, 1'b1, 1'b0, 10'd2, 6'd0, 0);
    run_instr(16'h0404, 0, 1'b0, 1'b1, 10'd0, 6'b111100, 0);
    checks++;
    if (pc !== 10'd1022) begin
      errors++;
      $display("FAIL branch_neg_wrap: pc=%0d, want 1022", pc);
    end
    run_instr(16'h0505, 0, 1'b1, 1'b0, 10'd1023, 6'd0, 0);
    run_instr(16'h0606, 0, 1'b0, 1'b0, 10'd0, 6'd0, 0);
    checks++;
    if (pc !== 10'd0) begin
      errors++;
      $display("FAIL inc_wrap: pc=%0d, want 0", pc);
    end
    run_instr(16'h0707, 0, 1'b1, 1'b0, 10'd1020, 6'd0, 0);
    run_instr(16'h0808, 0, 1'b0, 1'b1, 10'd0, 6'd10, 0);
    checks++;
    if (pc !== 10'd6) begin
      errors++;
      $display("FAIL branch_pos_wrap: pc=%0d, want 6", pc);
    end
  endtask

  task automatic test_reset_decode();
    run_instr(16'h0909, 0, 1'b1, 1'b0, 10'd77, 6'd0, 0);
    run          = 1'b1;
    bus.imemAck  = 1'b1;
    bus.imemData = 16'hABCD;
    tick();
    checks++;
    if (state !== 2'd1 || ir !== 16'hABCD) begin
      errors++;
      $display("FAIL pre_reset_decode: state=%0d ir=%h, want 1 abcd", state, ir);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 2'd0 || pc !== 10'd0 || ir !== 16'h0000 || execStrobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_decode: state=%0d pc=%0d ir=%h exec=%b, want 0 0 0000 0",
               state, pc, ir, execStrobe);
    end
    reset = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (execStrobe !== 1'b0 || state !== 2'd0 || pc !== 10'd0) begin
        errors++;
        $display("FAIL no_strobe_after_reset c%0d: exec=%b state=%0d pc=%0d, want 0 0 0",
                 i, execStrobe, state, pc);
      end
    end
    m_pc = 0;
    m_ir = 16'h0000;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr(16'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), 10'($urandom), 6'($urandom),
                int'($urandom_range(0, 2)));
    end
  endtask

`ifdef FETCH_SEQ_STEP_EN
  task automatic test_step();
    int strobes;
    run_instr(16'h4242, 0, 1'b0, 1'b0, 10'd0, 6'd0, 10);
    strobes      = 0;
    run          = 1'b1;
    bus.imemAck  = 1'b1;
    bus.imemData = 16'h5151;
    for (int i = 0; i < 12; i++) begin
      if (execStrobe === 1'b1) strobes++;
      tick();
    end
    checks++;
    if (strobes != 1 || state !== 2'd3) begin
      errors++;
      $display("FAIL single_step: strobes=%0d state=%0d, want 1 3", strobes, state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (state !== 2'd0 || pc !== 10'd0) begin
      errors++;
      $display("FAIL reset_in_hold: state=%0d pc=%0d, want 0 0", state, pc);
    end
    m_pc = 0;
    m_ir = 16'h0000;
  endtask
`endif

  initial begin
    reset        = 1'b1;
    run          = 1'b0;
    jmpEnable    = 1'b0;
    branchEnable = 1'b0;
    jmpDir       = '0;
    branchDir    = '0;
    bus.imemAck  = 1'b0;
    bus.imemData = '0;
`ifdef FETCH_SEQ_STEP_EN
    stepReq      = 1'b0;
`endif
    m_pc         = 0;
    m_ir         = 16'h0000;
    #1;
    test_reset();
    test_basic();
    test_ack_delay();
    test_jump_priority();
    test_branch_wrap();
    test_reset_decode();
    test_random();
`ifdef FETCH_SEQ_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
